// File: rtl/iter_muldiv_pkg.sv
// Shared constants and types for the iterative multiply/divide unit.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package iter_muldiv_pkg;

   localparam int   DEFAULT_WIDTH = 32;

   localparam logic FUNCT_MUL = 1'b0;
   localparam logic FUNCT_DIV = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of unsigned shift-add multiply or restoring divide.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module muldiv_step
   import iter_muldiv_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
)
(
   input  logic               funct,
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH:0]     rem,
   input  logic [WIDTH-1:0]   opb,
   output logic [2*WIDTH-1:0] acc_nxt,
   output logic [WIDTH:0]     rem_nxt
);

   // Multiply: acc = {partial product high, remaining multiplier bits}.
   // Divide:   acc[WIDTH-1:0] shifts dividend bits out of the top and
   //           quotient bits in at the bottom; rem is the partial remainder.
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH+1:0] div_shift;
   logic             div_fit;

   // Compute both candidate iterations and select by operation.
   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]}
                + {1'b0, (acc[0] ? opb : {WIDTH{1'b0}})};
      div_shift = {rem, acc[WIDTH-1]};
      div_fit   = (div_shift >= {2'b00, opb});
      acc_nxt   = acc;
      rem_nxt   = rem;
      if (funct == FUNCT_MUL) begin
         // carry of the add lands in the top bit after the right shift
         acc_nxt = {mul_sum, acc[WIDTH-1:1]};
      end else begin
         acc_nxt = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], div_fit};
         rem_nxt = div_fit ? (WIDTH+1)'(div_shift - {2'b00, opb})
                           : div_shift[WIDTH:0];
      end
   end

endmodule

// File: rtl/iter_muldiv.sv
// Iterative unsigned multiply/divide, one bit per cycle (WIDTH >= 2).
// Latency: WIDTH+1 cycles from accepted start to done; divide-by-zero 1 cycle.
// Backpressure: start is only accepted in IDLE; requests while busy are dropped.
module iter_muldiv
   import iter_muldiv_pkg::*;
#(
   parameter int               WIDTH    = DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] DBZ_QUOT = {WIDTH{1'b1}}
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             funct,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] calres,
   output logic [WIDTH-1:0] calrem,
   output logic             ovf,
   output logic             dbz
);

   localparam int CW = $clog2(WIDTH) + 1;

   state_t             state, state_nxt;
   logic [CW-1:0]      cnt;
   logic               op_funct;
   logic [WIDTH-1:0]   op_b;
   logic [2*WIDTH-1:0] acc, acc_nxt;
   logic [WIDTH:0]     rem, rem_nxt;
   logic               accept, dbz_start, last_iter;

   assign accept    = (state == ST_IDLE) && start;
   assign dbz_start = accept && (funct == FUNCT_DIV) && (b == '0);
   assign last_iter = (state == ST_RUN) && (cnt == CW'(WIDTH - 1));

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .funct   (op_funct),
      .acc     (acc),
      .rem     (rem),
      .opb     (op_b),
      .acc_nxt (acc_nxt),
      .rem_nxt (rem_nxt)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next-state: divide-by-zero skips RUN entirely.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (accept)    state_nxt = dbz_start ? ST_DONE : ST_RUN;
         ST_RUN:  if (last_iter) state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Status outputs decoded from state.
   always_comb begin
      busy = (state != ST_IDLE);
      done = (state == ST_DONE);
   end

   // Iteration counter: cleared on accept, stops at the last iteration.
   always_ff @(posedge clk) begin
      if (rst)                           cnt <= '0;
      else if (accept)                   cnt <= '0;
      else if (state == ST_RUN && !last_iter) cnt <= cnt + 1'b1;
   end

   // Operand capture on accept, then one step per RUN cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_funct <= FUNCT_MUL;
         op_b     <= '0;
         acc      <= '0;
         rem      <= '0;
      end else if (accept) begin
         op_funct <= funct;
         // mul: a is the multiplicand added in, b is shifted out LSB first
         // div: a is shifted out MSB first, b is the divisor
         op_b     <= (funct == FUNCT_MUL) ? a : b;
         acc      <= {{WIDTH{1'b0}}, ((funct == FUNCT_MUL) ? b : a)};
         rem      <= '0;
      end else if (state == ST_RUN) begin
         acc      <= acc_nxt;
         rem      <= rem_nxt;
      end
   end

   // Result registers: load only on entry to DONE, hold otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         calres <= '0;
         calrem <= '0;
         ovf    <= 1'b0;
         dbz    <= 1'b0;
      end else if (dbz_start) begin
         calres <= DBZ_QUOT;
         calrem <= a;
         ovf    <= 1'b0;
         dbz    <= 1'b1;
      end else if (last_iter) begin
         calres <= acc_nxt[WIDTH-1:0];
         dbz    <= 1'b0;
         if (op_funct == FUNCT_MUL) begin
            calrem <= acc_nxt[2*WIDTH-1:WIDTH];
            ovf    <= |acc_nxt[2*WIDTH-1:WIDTH];
         end else begin
            calrem <= rem_nxt[WIDTH-1:0];
            ovf    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_iter_muldiv.sv
// Self-checking bench for iter_muldiv against an arithmetic reference model.
// Latency: checks done timing relative to the start edge.
// Backpressure: checks start is ignored while busy and in the DONE cycle.
module tb_iter_muldiv;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst, start, funct;
   logic [W-1:0] a, b, calres, calrem;
   logic         busy, done, ovf, dbz;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   iter_muldiv #(.WIDTH(W), .DBZ_QUOT({W{1'b1}})) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .funct  (funct),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .calres (calres),
      .calrem (calrem),
      .ovf    (ovf),
      .dbz    (dbz)
   );

   typedef struct {
      logic         f;
      logic [W-1:0] x, y, q, r;
      logic         o, z;
      int           lat;
   } vec_t;

   // Reference: plain wide multiply, / and %.
   function automatic void model(input logic f, input logic [W-1:0] x, y,
                                 output logic [W-1:0] q, r, output logic o, z);
      logic [2*W-1:0] p;
      p = '0;
      if (f == 1'b0) begin
         p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
         q = p[W-1:0];
         r = p[2*W-1:W];
         o = (r != '0);
         z = 1'b0;
      end else if (y == '0) begin
         q = {W{1'b1}};
         r = x;
         o = 1'b0;
         z = 1'b1;
      end else begin
         q = x / y;
         r = x % y;
         o = 1'b0;
         z = 1'b0;
      end
   endfunction

   // Launch one op and wait for done; cyc = edges from start edge (inclusive), -1 on timeout.
   task automatic do_op(input logic f, input logic [W-1:0] x, y, output int cyc);
      funct = f; a = x; b = y; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; funct = ~f; a = $urandom; b = $urandom;
      cyc = 1;
      while (!done && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      if (!done) cyc = -1;
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; funct = 1'b0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      n_checks++;
      if ({busy, done, ovf, dbz} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_flags: got busy/done/ovf/dbz=%b expected 0000", {busy, done, ovf, dbz});
      end
      n_checks++;
      if (calres !== '0 || calrem !== '0) begin
         n_fail++;
         $display("FAIL reset_results: got calres=%h calrem=%h expected 0", calres, calrem);
      end
   endtask

   task automatic test_directed;
      vec_t v[7];
      int   cyc;
      v[0] = '{1'b0, 32'd3,          32'd5,  32'd15,         32'd0, 1'b0, 1'b0, W+1};
      v[1] = '{1'b0, 32'hFFFFFFFF,   32'd2,  32'hFFFFFFFE,   32'd1, 1'b1, 1'b0, W+1};
      v[2] = '{1'b1, 32'd100,        32'd7,  32'd14,         32'd2, 1'b0, 1'b0, W+1};
      v[3] = '{1'b1, 32'd5,          32'd0,  32'hFFFFFFFF,   32'd5, 1'b0, 1'b1, 1};
      v[4] = '{1'b0, 32'd0,          32'd123,32'd0,          32'd0, 1'b0, 1'b0, W+1};
      v[5] = '{1'b0, 32'd77,         32'd0,  32'd0,          32'd0, 1'b0, 1'b0, W+1};
      v[6] = '{1'b1, 32'd6,          32'd9,  32'd0,          32'd6, 1'b0, 1'b0, W+1};
      foreach (v[i]) begin
         do_op(v[i].f, v[i].x, v[i].y, cyc);
         n_checks++;
         if (cyc !== v[i].lat) begin
            n_fail++;
            $display("FAIL dir%0d_latency: got %0d expected %0d", i, cyc, v[i].lat);
         end
         n_checks++;
         if (calres !== v[i].q || calrem !== v[i].r) begin
            n_fail++;
            $display("FAIL dir%0d_result: got %h/%h expected %h/%h", i, calres, calrem, v[i].q, v[i].r);
         end
         n_checks++;
         if (ovf !== v[i].o || dbz !== v[i].z) begin
            n_fail++;
            $display("FAIL dir%0d_flags: got ovf=%b dbz=%b expected ovf=%b dbz=%b", i, ovf, dbz, v[i].o, v[i].z);
         end
         @(posedge clk); #1;
         n_checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL dir%0d_pulse: got done=%b busy=%b expected 0 0", i, done, busy);
         end
      end
   endtask

   task automatic test_random(input logic f);
      logic [W-1:0] x, y, q, r;
      logic         o, z;
      int           cyc;
      for (int i = 0; i < 25; i++) begin
         x = $urandom;
         y = $urandom;
         if (f && (i % 5) == 0) y = '0;
         else if (f && (i % 3) == 0) y = W'($urandom_range(1, 300));
         else if (!f && (i % 4) == 0) y = W'($urandom_range(0, 15));
         model(f, x, y, q, r, o, z);
         do_op(f, x, y, cyc);
         n_checks++;
         if (cyc !== ((f && y == '0) ? 1 : W + 1)) begin
            n_fail++;
            $display("FAIL rnd_%s%0d_latency: got %0d for a=%h b=%h", f ? "div" : "mul", i, cyc, x, y);
         end
         n_checks++;
         if (calres !== q || calrem !== r || ovf !== o || dbz !== z) begin
            n_fail++;
            $display("FAIL rnd_%s%0d: a=%h b=%h got %h/%h ovf=%b dbz=%b expected %h/%h ovf=%b dbz=%b",
                     f ? "div" : "mul", i, x, y, calres, calrem, ovf, dbz, q, r, o, z);
         end
         // results hold through idle cycles with wandering inputs
         repeat (3) begin
            a = $urandom; b = $urandom; funct = $urandom;
            @(posedge clk); #1;
         end
         n_checks++;
         if (calres !== q || calrem !== r || done !== 1'b0) begin
            n_fail++;
            $display("FAIL rnd_%s%0d_hold: got %h/%h done=%b expected %h/%h done=0",
                     f ? "div" : "mul", i, calres, calrem, done, q, r);
         end
      end
   endtask

   task automatic test_ignore_start;
      logic [W-1:0] x, y, q, r;
      logic         o, z;
      int           ndone, first_done;
      x = $urandom; y = $urandom;
      model(1'b0, x, y, q, r, o, z);
      funct = 1'b0; a = x; b = y; start = 1'b1;
      @(posedge clk); #1;
      ndone = 0; first_done = 0;
      for (int i = 2; i <= W + 6; i++) begin
         if (i == 10 || i == W + 2) begin
            start = 1'b1; funct = 1'b1; a = $urandom; b = $urandom;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         if (done) begin
            ndone++;
            if (first_done == 0) first_done = i;
         end
      end
      start = 1'b0;
      n_checks++;
      if (ndone !== 1 || first_done !== W + 1) begin
         n_fail++;
         $display("FAIL ignore_start_done: got %0d pulses first at %0d expected 1 at %0d", ndone, first_done, W + 1);
      end
      n_checks++;
      if (calres !== q || calrem !== r || ovf !== o) begin
         n_fail++;
         $display("FAIL ignore_start_result: got %h/%h ovf=%b expected %h/%h ovf=%b", calres, calrem, ovf, q, r, o);
      end
   endtask

   task automatic test_back_to_back;
      int d[$];
      funct = 1'b1; a = 32'd1000; b = 32'd33; start = 1'b1;
      for (int i = 1; i <= 3 * (W + 2) + 2; i++) begin
         @(posedge clk); #1;
         if (done) d.push_back(i);
      end
      start = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (d.size() < 3) begin
         n_fail++;
         $display("FAIL b2b_count: got %0d done pulses expected at least 3", d.size());
      end else begin
         n_checks++;
         if (d[0] !== W + 1 || d[1] - d[0] !== W + 2 || d[2] - d[1] !== W + 2) begin
            n_fail++;
            $display("FAIL b2b_interval: got done at %0d,%0d,%0d expected %0d,%0d,%0d",
                     d[0], d[1], d[2], W + 1, 2 * W + 3, 3 * W + 5);
         end
      end
      n_checks++;
      if (calres !== 32'd30 || calrem !== 32'd10) begin
         n_fail++;
         $display("FAIL b2b_result: got %h/%h expected 0000001e/0000000a", calres, calrem);
      end
   endtask

   task automatic test_reset_mid;
      logic [W-1:0] x, y, q, r;
      logic         o, z;
      int           ndone, cyc;
      funct = 1'b0; a = 32'hDEADBEEF; b = 32'h12345; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (13) @(posedge clk);
      #1;
      // reset and a competing start land on the same edge
      rst = 1'b1; start = 1'b1; funct = 1'b0; a = 32'd9; b = 32'd9;
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      n_checks++;
      if ({busy, done, ovf, dbz} !== 4'b0000 || calres !== '0 || calrem !== '0) begin
         n_fail++;
         $display("FAIL rst_mid_state: got busy=%b done=%b ovf=%b dbz=%b calres=%h calrem=%h expected all 0",
                  busy, done, ovf, dbz, calres, calrem);
      end
      ndone = 0;
      repeat (W + 5) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      n_checks++;
      if (ndone !== 0) begin
         n_fail++;
         $display("FAIL rst_mid_no_done: got %0d done pulses expected 0", ndone);
      end
      x = $urandom; y = $urandom;
      model(1'b0, x, y, q, r, o, z);
      do_op(1'b0, x, y, cyc);
      n_checks++;
      if (cyc !== W + 1 || calres !== q || calrem !== r || ovf !== o) begin
         n_fail++;
         $display("FAIL rst_mid_recover: got cyc=%0d %h/%h ovf=%b expected cyc=%0d %h/%h ovf=%b",
                  cyc, calres, calrem, ovf, W + 1, q, r, o);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random(1'b0);
      test_random(1'b1);
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/iter_muldiv.md
ITER_MULDIV -- requirements
Module: iter_muldiv

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; DBZ_QUOT, default all-ones, quotient returned on divide-by-zero.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  request; sampled only in IDLE.
REQ-005 funct  in  1  0 = unsigned multiply, 1 = unsigned divide; captured with start.
REQ-006 a, b  in  WIDTH  operands (multiplicand/multiplier, dividend/divisor); captured with start.
REQ-007 busy  out  1  high while an operation is in progress.
REQ-008 done  out  1  one-cycle pulse marking valid results.
REQ-009 calres  out  WIDTH  product low word or quotient.
REQ-010 calrem  out  WIDTH  product high word (mul) or remainder (div).
REQ-011 ovf  out  1  multiply overflow: product high word nonzero; always 0 for divide.
REQ-012 dbz  out  1  divide-by-zero flag; always 0 for multiply.

Function
REQ-013 FSM states IDLE, RUN, DONE; IDLE->RUN on start (b!=0 or funct=0); IDLE->DONE on start with funct=1 and b=0; RUN->DONE after WIDTH iterations; DONE->IDLE unconditionally.
REQ-014 Start edge captures a, b and funct into internal registers; later input changes do not affect the operation.
REQ-015 Multiply: shift-add, one multiplier bit per cycle, LSB first, 2*WIDTH-bit accumulator, unsigned.
REQ-016 Divide: restoring, one quotient bit per cycle, MSB first, WIDTH+1-bit partial remainder, unsigned.
REQ-017 Iteration counter clog2(WIDTH)+1 bits, loaded 0 at start, RUN exits when count reaches WIDTH-1 after the final iteration.
REQ-018 Latency: normal op, done high in the cycle after WIDTH RUN cycles, i.e. WIDTH+1 cycles after start edge; divide-by-zero, done high 1 cycle after start edge.
REQ-019 busy high in RUN and DONE, low in IDLE.
REQ-020 done high only in DONE, exactly one cycle per accepted start.
REQ-021 calres, calrem, ovf, dbz update only on entry to DONE and hold until the next DONE entry.
REQ-022 Divide-by-zero: calres=DBZ_QUOT, calrem=a, dbz=1, ovf=0.
REQ-023 start while busy is ignored; no queuing; the in-flight op completes unaffected.
REQ-024 start in DONE cycle ignored; earliest accepted start is the first IDLE cycle (back-to-back interval WIDTH+2 cycles).
REQ-025 a=0 or b=0 on multiply: full WIDTH cycles, result 0, ovf=0 (no early termination).
REQ-026 Divide with a<b: quotient 0, remainder a.

Reset
REQ-027 rst high at a clock edge forces IDLE, counter 0, busy=0, done=0, calres=0, calrem=0, ovf=0, dbz=0.
REQ-028 rst mid-operation aborts the op with no done pulse; rst dominates start in the same cycle.

Structure
REQ-029 Shared package holds FUNCT_MUL=1'b0, FUNCT_DIV=1'b1, state-encoding typedef, and default WIDTH constant.
REQ-030 One combinational sub-module muldiv_step computes a single shift-add or restore-subtract iteration; iter_muldiv holds FSM, counter, and registers.

Verification
REQ-031 mul a=3, b=5 -> done at cycle 33, calres=15, calrem=0, ovf=0.
REQ-032 mul a=32'hFFFFFFFF, b=2 -> calres=32'hFFFFFFFE, calrem=1, ovf=1.
REQ-033 div a=100, b=7 -> calres=14, calrem=2, dbz=0, ovf=0, done at cycle 33.
REQ-034 div a=5, b=0 -> done 1 cycle after start, calres=32'hFFFFFFFF, calrem=5, dbz=1.
REQ-035 start pulsed at cycle 10 of a running op with new operands -> ignored; single done, original result.
REQ-036 rst at cycle 15 of a multiply -> no done; outputs 0; next start yields a correct result.
